// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline datapath and the pipeline controller.
// Hazard inputs and data-memory status come in. Register enables, flushes,
// the memory request, status flags and the debug state go out.
//
// Memory handshake: dmem_req_o is the request (valid) and dmem_ready_i is the
// completion (ready). An access completes on a rising clk edge where both are 1.
// Once the controller has seen a request stall (MEM_WAIT), it holds
// dmem_req_o high until dmem_ready_i arrives. A timeout is the only exception.
interface pipe_ctrl_if;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic [4:0]  ex_rd_i;
    logic        ex_is_load_i;
    logic        ex_branch_taken_i;
    logic        mem_access_i;
    logic        dmem_ready_i;
    logic        pc_en_o;
    logic        if2id_en_o;
    logic        id2ex_en_o;
    logic        ex2mem_en_o;
    logic        if2id_flush_o;
    logic        id2ex_flush_o;
    logic        mem2wb_flush_o;
    logic        dmem_req_o;
    logic        dmem_timeout_o;
    logic [15:0] stall_cnt_o;
    logic [1:0]  state_o;      // debug: 0=RUN, 1=MEM_WAIT, 2=TIMEOUT

    // Controller side
    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        input  ex_rd_i, ex_is_load_i, ex_branch_taken_i,
        input  mem_access_i, dmem_ready_i,
        output pc_en_o, if2id_en_o, id2ex_en_o, ex2mem_en_o,
        output if2id_flush_o, id2ex_flush_o, mem2wb_flush_o,
        output dmem_req_o, dmem_timeout_o, stall_cnt_o, state_o
    );

    // Datapath / driver side
    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        output ex_rd_i, ex_is_load_i, ex_branch_taken_i,
        output mem_access_i, dmem_ready_i,
        input  pc_en_o, if2id_en_o, id2ex_en_o, ex2mem_en_o,
        input  if2id_flush_o, id2ex_flush_o, mem2wb_flush_o,
        input  dmem_req_o, dmem_timeout_o, stall_cnt_o, state_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller.
// Memory stalls take priority over branch flushes, and branch flushes take
// priority over load-use stalls. A data-memory wait longer than
// TIMEOUT_CYCLES locks the pipeline in TIMEOUT until reset.
// All control outputs are combinational from the state and the inputs.
module pipe_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
);

    localparam int WCW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WCW     = (WCW_RAW < 1) ? 1 : WCW_RAW;
    localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);
    // Last wait count before a timeout. It is only used when TO_EN is set.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WCW-1:0]   r_wait_cnt;
    logic [WCW-1:0]   w_wait_cnt_nxt;
    logic             r_timeout;
    logic             w_timeout_set;
    logic [15:0]      r_stall_cnt;

    logic             w_load_use;
    logic             w_pc_en;
    logic             w_if2id_en;
    logic             w_id2ex_en;
    logic             w_ex2mem_en;
    logic             w_if2id_flush;
    logic             w_id2ex_flush;
    logic             w_mem2wb_flush;
    logic             w_dmem_req;

    // Load-use hazard: the ID stage reads a register that a load in EX
    // has not yet produced. x0 never creates a hazard.
    always_comb begin
        w_load_use = bus.ex_is_load_i && (bus.ex_rd_i != 5'd0) &&
                     ((bus.id_rs1_used_i && (bus.id_rs1_i == bus.ex_rd_i)) ||
                      (bus.id_rs2_used_i && (bus.id_rs2_i == bus.ex_rd_i)));
    end

    // Next state, wait counter and prioritised stall/flush decode
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_set  = 1'b0;
        w_pc_en        = 1'b1;
        w_if2id_en     = 1'b1;
        w_id2ex_en     = 1'b1;
        w_ex2mem_en    = 1'b1;
        w_if2id_flush  = 1'b0;
        w_id2ex_flush  = 1'b0;
        w_mem2wb_flush = 1'b0;
        w_dmem_req     = 1'b0;

        case (r_state)
            RUN: begin
                w_dmem_req     = bus.mem_access_i;
                w_wait_cnt_nxt = '0;
                if (bus.mem_access_i && !bus.dmem_ready_i) begin
                    // Memory stall: freeze the front end and bubble WB
                    w_pc_en        = 1'b0;
                    w_if2id_en     = 1'b0;
                    w_id2ex_en     = 1'b0;
                    w_ex2mem_en    = 1'b0;
                    w_mem2wb_flush = 1'b1;
                    w_state_nxt    = MEM_WAIT;
                end else if (bus.ex_branch_taken_i) begin
                    // Taken branch: squash the two younger instructions
                    w_if2id_flush  = 1'b1;
                    w_id2ex_flush  = 1'b1;
                end else if (w_load_use) begin
                    // Load-use: hold PC and IF/ID, and insert a bubble into EX
                    w_pc_en        = 1'b0;
                    w_if2id_en     = 1'b0;
                    w_id2ex_flush  = 1'b1;
                end
            end
            MEM_WAIT: begin
                w_dmem_req = 1'b1;
                if (!bus.dmem_ready_i) begin
                    w_pc_en        = 1'b0;
                    w_if2id_en     = 1'b0;
                    w_id2ex_en     = 1'b0;
                    w_ex2mem_en    = 1'b0;
                    w_mem2wb_flush = 1'b1;
                    if (TO_EN && (r_wait_cnt == WAIT_LAST)) begin
                        w_state_nxt   = TIMEOUT;
                        w_timeout_set = 1'b1;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
                    end
                end else begin
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = RUN;
                end
            end
            TIMEOUT: begin
                // Dead-locked memory: hold everything and issue no requests
                w_pc_en     = 1'b0;
                w_if2id_en  = 1'b0;
                w_id2ex_en  = 1'b0;
                w_ex2mem_en = 1'b0;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase

        // During reset, hold every stage and flush the whole pipe
        if (!rst_n) begin
            w_pc_en        = 1'b0;
            w_if2id_en     = 1'b0;
            w_id2ex_en     = 1'b0;
            w_ex2mem_en    = 1'b0;
            w_if2id_flush  = 1'b1;
            w_id2ex_flush  = 1'b1;
            w_mem2wb_flush = 1'b1;
            w_dmem_req     = 1'b0;
        end
    end

    // FSM state, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= r_timeout | w_timeout_set;
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (!w_pc_en && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.pc_en_o        = w_pc_en;
    assign bus.if2id_en_o     = w_if2id_en;
    assign bus.id2ex_en_o     = w_id2ex_en;
    assign bus.ex2mem_en_o    = w_ex2mem_en;
    assign bus.if2id_flush_o  = w_if2id_flush;
    assign bus.id2ex_flush_o  = w_id2ex_flush;
    assign bus.mem2wb_flush_o = w_mem2wb_flush;
    assign bus.dmem_req_o     = w_dmem_req;
    assign bus.dmem_timeout_o = r_timeout;
    assign bus.stall_cnt_o    = r_stall_cnt;
    assign bus.state_o        = r_state;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n; the polarity and synchronicity are fixed.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: the number of MEM_WAIT cycles before the block declares a data-memory timeout; 0 disables the timeout.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- id_rs1_i / id_rs2_i  in  5  ID-stage source register addresses
- id_rs1_used_i / id_rs2_used_i  in  1  ID instruction reads rs1 / rs2
- ex_rd_i  in  5  EX-stage destination register
- ex_is_load_i  in  1  EX instruction is a load, i.e. its WB data comes from memory
- ex_branch_taken_i  in  1  EX resolved a taken branch or jump
- mem_access_i  in  1  MEM stage holds a load or store
- dmem_ready_i  in  1  data memory completes the current access this cycle
- pc_en_o, if2id_en_o, id2ex_en_o, ex2mem_en_o  out  1  register load enables; 0 means hold
- if2id_flush_o, id2ex_flush_o, mem2wb_flush_o  out  1  load a NOP bubble on the next edge
- dmem_req_o  out  1  data-memory request
- dmem_timeout_o  out  1  sticky timeout flag
- stall_cnt_o  out  16  count of frontend stall cycles

Function
REQ-004 FSM states SHALL be RUN, MEM_WAIT and TIMEOUT, with the state held in a flop.
REQ-005 dmem_req_o SHALL equal mem_access_i in RUN, equal 1 in MEM_WAIT, and equal 0 in TIMEOUT.
REQ-006 RUN with mem_access_i=1 and dmem_ready_i=0 SHALL act as a memory stall:
- all four enables = 0
- mem2wb_flush_o = 1
- next state = MEM_WAIT
REQ-007 RUN with mem_access_i=1 and dmem_ready_i=1 SHALL NOT stall and SHALL stay in RUN.
REQ-008 MEM_WAIT with dmem_ready_i=0 SHALL freeze the pipeline exactly as in REQ-006 and SHALL increment the wait counter.
REQ-009 MEM_WAIT with dmem_ready_i=1 SHALL:
- drive all enables = 1 and mem2wb_flush_o = 0
- clear the wait counter
- move to RUN on the next edge
REQ-010 When TIMEOUT_CYCLES>0 and the wait counter reaches TIMEOUT_CYCLES-1 while dmem_ready_i=0, the next state SHALL be TIMEOUT and dmem_timeout_o SHALL be set.
REQ-011 TIMEOUT SHALL drive all enables = 0 and all flushes = 0, and SHALL be left only by reset.
REQ-012 The wait counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide, minimum 1.
REQ-013 A branch flush SHALL apply in RUN with no memory stall and ex_branch_taken_i=1:
- if2id_flush_o = 1, id2ex_flush_o = 1
- all enables = 1
REQ-014 A load-use hazard SHALL be ex_is_load_i & (ex_rd_i != 0) & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)).
REQ-015 A load-use hazard in RUN, with no memory stall and no branch, SHALL drive:
- pc_en_o = 0, if2id_en_o = 0
- id2ex_flush_o = 1
- id2ex_en_o = 1, ex2mem_en_o = 1
REQ-016 Priority SHALL be memory stall, then branch flush, then load-use; a lower-priority condition SHALL have no effect while a higher-priority one is active.
REQ-017 With no condition active, all enables SHALL be 1 and all flushes 0.
REQ-018 stall_cnt_o SHALL increment on each clock edge where rst_n=1 and pc_en_o=0, and SHALL saturate at 0xFFFF.
REQ-019 All enable, flush and request outputs SHALL be combinational from the state and inputs, with no added latency.

Reset
REQ-020 While rst_n=0, the outputs SHALL be:
- all enables = 0
- if2id_flush_o, id2ex_flush_o, mem2wb_flush_o = 1
- dmem_req_o = 0
REQ-021 Asserting rst_n SHALL asynchronously return the block to RUN and clear the wait counter, dmem_timeout_o and stall_cnt_o, including mid-MEM_WAIT and from TIMEOUT.
REQ-022 After rst_n deasserts, the block SHALL behave per REQ-017 from the first edge.

Verification
REQ-023 Load-use: ex_is_load_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_used_i=1 for 1 cycle -> pc_en_o=0, if2id_en_o=0, id2ex_flush_o=1; stall_cnt_o goes 0 to 1.
REQ-024 No false hazard: ex_rd_i=0 with a load and a matching rs1 -> no stall, all enables 1.
REQ-025 Branch plus load-use in the same cycle -> if2id_flush_o=1, id2ex_flush_o=1, pc_en_o=1 (branch wins).
REQ-026 Memory wait: mem_access_i=1 with dmem_ready_i low for 3 cycles, then high -> all enables 0 and mem2wb_flush_o=1 for 3 cycles, enables 1 on cycle 4, back in RUN, stall_cnt_o=3.
REQ-027 Timeout: TIMEOUT_CYCLES=4 with dmem_ready_i held 0 -> dmem_timeout_o=1 after 5 edges, enables stay 0; pulsing rst_n low clears the flag and stall_cnt_o.
REQ-028 Reset mid-MEM_WAIT: rst_n low for 1 cycle -> state RUN, dmem_req_o follows mem_access_i on the first cycle after release.
